// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the fetch/load-store memory arbiter.
package memory_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_START = 3'd1,
        ARB_WAIT  = 3'd2,
        ARB_RESP  = 3'd3,
        ARB_ERR   = 3'd4
    } arb_state_t;

    localparam logic [2:0] MEM_MODE_BYTE     = 3'b000;
    localparam logic [2:0] MEM_MODE_HALF     = 3'b001;
    localparam logic [2:0] MEM_MODE_WORD     = 3'b010;
    localparam logic [2:0] MEM_MODE_UNSIGNED = 3'b100;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } grant_t;

    // Word needs addr[1:0]==0, half needs addr[0]==0, bytes never fault.
    function automatic logic misaligned(
        input logic [2:0] mode,
        input logic [1:0] addr_lo
    );
        misaligned = mode[1] ? (addr_lo != 2'b00)
                             : (mode[0] & addr_lo[0]);
    endfunction

endpackage

// File: rtl/memory_arbiter_pick.sv
// Combinational winner selection between fetch and load/store requests.
module memory_arbiter_pick
    import memory_arbiter_pkg::*;
#(
    parameter int ARB_MODE = 0
) (
    input  logic   if_req,
    input  logic   d_req,
    input  grant_t last_grant,
    output logic   valid,
    output grant_t grant
);

    localparam bit RR = (ARB_MODE != 0);

    always_comb begin
        valid = if_req | d_req;
        grant = GRANT_D;
        unique case (1'b1)
            (if_req && !d_req): grant = GRANT_IF;
            (if_req && d_req && RR && last_grant == GRANT_D):
                grant = GRANT_IF;
            default: grant = GRANT_D;
        endcase
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares the byte-serial memory controller between fetch and load/store,
// with alignment checking and a timeout on a hung controller.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic        if_err,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_mode,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mc_start,
    output logic [31:0] mc_address,
    output logic [2:0]  mc_mode,
    output logic        mc_we,
    output logic [31:0] mc_wdata,
    input  logic        mc_done,
    input  logic [31:0] mc_rdata
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    arb_state_t    state, state_nxt;
    grant_t        grant, last_grant, pick_grant, cap_grant;
    logic          pick_valid;
    logic [TW-1:0] to_cnt;
    logic [31:0]   req_addr, req_wdata, cap_val;
    logic [2:0]    req_mode;
    logic          req_we, cap_en;

    memory_arbiter_pick #(.ARB_MODE(ARB_MODE)) u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .grant      (pick_grant)
    );

    always_comb begin
        req_addr  = d_addr;
        req_mode  = d_mode;
        req_we    = d_we;
        req_wdata = d_wdata;
        if (pick_grant == GRANT_IF) begin
            req_addr  = if_addr;
            req_mode  = MEM_MODE_WORD;
            req_we    = 1'b0;
            req_wdata = '0;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB_IDLE:
                if (pick_valid)
                    state_nxt = misaligned(req_mode, req_addr[1:0])
                              ? ARB_ERR : ARB_START;
            ARB_START: state_nxt = ARB_WAIT;
            ARB_WAIT:
                // A done level left over from the last access is ignored.
                if (to_cnt != '0 && mc_done)
                    state_nxt = ARB_RESP;
                else if (to_cnt == TO_LAST - 1'b1)
                    state_nxt = ARB_ERR;
            ARB_RESP:  state_nxt = ARB_IDLE;
            ARB_ERR:   state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        cap_en    = (state_nxt == ARB_RESP) || (state_nxt == ARB_ERR);
        cap_grant = (state == ARB_IDLE) ? pick_grant : grant;
        cap_val   = (state_nxt == ARB_RESP && !mc_we) ? mc_rdata : '0;
    end

    assign mc_start = (state == ARB_START);
    assign if_ack   = (state == ARB_RESP || state == ARB_ERR)
                    && grant == GRANT_IF;
    assign d_ack    = (state == ARB_RESP || state == ARB_ERR)
                    && grant == GRANT_D;
    assign if_err   = (state == ARB_ERR) && grant == GRANT_IF;
    assign d_err    = (state == ARB_ERR) && grant == GRANT_D;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            grant      <= GRANT_IF;
            last_grant <= GRANT_IF;
            to_cnt     <= '0;
            mc_address <= '0;
            mc_mode    <= '0;
            mc_we      <= 1'b0;
            mc_wdata   <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE && pick_valid) begin
                grant      <= pick_grant;
                mc_address <= req_addr;
                mc_mode    <= req_mode;
                mc_we      <= req_we;
                mc_wdata   <= req_wdata;
            end
            if (state == ARB_START)
                to_cnt <= '0;
            else if (state == ARB_WAIT && to_cnt != TO_LAST)
                to_cnt <= to_cnt + 1'b1;
            if (cap_en) begin
                if (cap_grant == GRANT_IF)
                    if_rdata <= cap_val;
                else
                    d_rdata <= cap_val;
            end
            if (state == ARB_RESP)
                last_grant <= grant;
        end
    end

endmodule
